// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data port and a multi-cycle memory.
// Stores retire in one cycle and drain over mem_req/mem_ack. Loads forward from the
// buffer or stall the core while a memory read is performed.
// Ports:
//   clk, reset (async, active-low)
//   MemWrite, MemRead, DataAdr, WriteData : core data port requests
//   ReadData, Stall                       : load data and PC-enable gate to the core
//   mem_req, mem_we, mem_adr, mem_wdata   : memory request (registered, held to ack)
//   mem_rdata, mem_ack                    : memory response
// Optional build macro STORE_COALESCE_EN: a store to the address of the tail-most
// entry (when that entry is not the in-flight head) overwrites it in place.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [31:0]   DataAdr,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_BUSY = 2'd1;
    localparam logic [1:0] RD_BUSY = 2'd2;
    localparam logic [1:0] RD_DONE = 2'd3;

    logic [AW-1:0] adr_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [1:0]    state;
    logic [31:0]   rd_hold;
    logic [31:0]   rd_last;

    logic [AW-1:0] ld_adr;
    logic          load;
    logic          hit;
    logic [31:0]   hit_data;
    logic [PW-1:0] idx;
    logic          full;
    logic          miss;
    logic          merge;
    logic [PW-1:0] last_idx;
    logic          push;
    logic          pop;
    logic          unused_ok;

    assign ld_adr    = DataAdr[AW+1:2];
    assign unused_ok = ^DataAdr[1:0];
    assign load      = MemRead & ~MemWrite;
    assign full      = (count == (PW+1)'(DEPTH));
    assign last_idx  = tail - PW'(1);

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((PW+1)'(i) < count && adr_q[idx] == ld_adr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign miss = load & ~hit;

`ifdef STORE_COALESCE_EN
    // With one entry in WR_BUSY the tail-most entry is the in-flight head.
    assign merge = MemWrite && count != '0 && adr_q[last_idx] == ld_adr &&
                   state != RD_BUSY && !(state == WR_BUSY && count == (PW+1)'(1));
`else
    assign merge = 1'b0;
`endif

    assign push = MemWrite && !full && state != RD_BUSY && !merge;
    assign pop  = (state == WR_BUSY) && mem_ack;

    assign Stall = reset & ((MemWrite & ((full & ~merge) | (state == RD_BUSY))) |
                            (miss & (state != RD_DONE)));

    assign ReadData = (state == RD_DONE) ? rd_hold :
                      (load && hit)      ? hit_data : rd_last;

    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[tail]  <= ld_adr;
            data_q[tail] <= WriteData;
        end
        if (merge) begin
            data_q[last_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= IDLE;
            rd_hold   <= '0;
            rd_last   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else begin
            rd_last <= ReadData;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        state   <= RD_BUSY;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        mem_adr <= ld_adr;
                    end else if (count != '0) begin
                        state     <= WR_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_adr   <= adr_q[head];
                        // A same-cycle merge into the launching head must be sent.
                        mem_wdata <= (merge && count == (PW+1)'(1)) ?
                                     WriteData : data_q[head];
                    end
                end
                WR_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rd_hold <= mem_rdata;
                        state   <= RD_DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
